// File: rtl/sign_mag_accumulator_if.sv
// Operand/result bus for the sign-magnitude block accumulator.
// Both channels use valid/ready: a beat moves on a rising edge when valid && ready; the source holds its payload steady until then.
interface sign_mag_accumulator_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sign_mag_accumulator.sv
// Sums DEPTH sign-magnitude operands per block and presents the result with a sticky overflow flag.
// The result is held in DONE until it is taken; the accumulator restarts from +0 for every block.
module sign_mag_accumulator #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sign_mag_accumulator_if.slave bus,
  output logic [1:0]           dbg_state_o
);
  localparam int M  = N - 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           acc_sign_q, acc_sign_d;
  logic [M-1:0]   acc_mag_q, acc_mag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  logic           accept;
  logic           transfer;
  logic           op_sign;
  logic [M-1:0]   op_mag;
  logic [N-1:0]   sum;
  logic           res_sign;
  logic [M-1:0]   res_mag;
  logic           res_ovf;

  assign bus.in_ready  = (state_q != DONE) && !rst;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.out_data  = {acc_sign_q, acc_mag_q};
  assign bus.out_ovf   = ovf_q;
  assign dbg_state_o   = state_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign transfer = bus.out_valid && bus.out_ready;

  // A -0 operand collapses to +0, so in_sub only flips non-zero magnitudes.
  always_comb begin
    op_mag   = bus.in_data[M-1:0];
    op_sign  = (op_mag != '0) && (bus.in_data[N-1] ^ bus.in_sub);
    sum      = {1'b0, acc_mag_q} + {1'b0, op_mag};
    res_sign = acc_sign_q;
    res_mag  = acc_mag_q;
    res_ovf  = 1'b0;
    if (acc_sign_q == op_sign) begin
      res_ovf = sum[N-1];
      res_mag = (sum[N-1] && (SAT != 0)) ? {M{1'b1}} : sum[M-1:0];
    end else if (acc_mag_q >= op_mag) begin
      res_mag = acc_mag_q - op_mag;
    end else begin
      res_sign = op_sign;
      res_mag  = op_mag - acc_mag_q;
    end
    if (res_mag == '0) res_sign = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    acc_sign_d = acc_sign_q;
    acc_mag_d  = acc_mag_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_sign_d = res_sign;
          acc_mag_d  = res_mag;
          ovf_d      = ovf_q | res_ovf;
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = ACC;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (transfer) begin
          state_d    = IDLE;
          acc_sign_d = 1'b0;
          acc_mag_d  = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_sign_q <= 1'b0;
      acc_mag_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_sign_q <= acc_sign_d;
      acc_mag_q  <= acc_mag_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_sign_mag_accumulator.sv
// Bench for sign_mag_accumulator: SAT=1 and SAT=0 copies share one stimulus stream, a DEPTH=1 copy runs on its own.
// Results are compared against an integer-arithmetic reference model.
module tb_sign_mag_accumulator;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       drv_valid = 1'b0;
  logic [7:0] drv_data  = '0;
  logic       drv_sub   = 1'b0;
  logic       drv_rdy   = 1'b1;
  logic       c_valid   = 1'b0;
  logic [7:0] c_data    = '0;
  logic       c_sub     = 1'b0;
  logic       c_rdy     = 1'b1;
  bit         rand_rdy  = 1'b0;
  logic [1:0] dbg_a, dbg_b, dbg_c;

  sign_mag_accumulator_if #(.N(8)) a_if ();
  sign_mag_accumulator_if #(.N(8)) b_if ();
  sign_mag_accumulator_if #(.N(8)) c_if ();

  assign a_if.in_valid  = drv_valid;
  assign a_if.in_data   = drv_data;
  assign a_if.in_sub    = drv_sub;
  assign a_if.out_ready = drv_rdy;
  assign b_if.in_valid  = drv_valid;
  assign b_if.in_data   = drv_data;
  assign b_if.in_sub    = drv_sub;
  assign b_if.out_ready = drv_rdy;
  assign c_if.in_valid  = c_valid;
  assign c_if.in_data   = c_data;
  assign c_if.in_sub    = c_sub;
  assign c_if.out_ready = c_rdy;

  sign_mag_accumulator #(.N(8), .DEPTH(4), .SAT(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave), .dbg_state_o(dbg_a));
  sign_mag_accumulator #(.N(8), .DEPTH(4), .SAT(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave), .dbg_state_o(dbg_b));
  sign_mag_accumulator #(.N(8), .DEPTH(1), .SAT(1)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave), .dbg_state_o(dbg_c));

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [7:0]   blk_d[4];
  logic         blk_s[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed integer running sum, clamped or wrapped in magnitude whenever |sum| > 127.
  function automatic logic [W-1:0] model_result(input bit sat, input int n);
    int acc = 0;
    int op;
    int mag;
    bit ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      mag = int'(blk_d[i][6:0]);
      op  = blk_d[i][7] ? -mag : mag;
      if (blk_s[i]) op = -op;
      acc = acc + op;
      if (acc > 127 || acc < -127) begin
        ovf = 1'b1;
        mag = sat ? 127 : ((acc < 0 ? -acc : acc) % 128);
        acc = (acc < 0) ? -mag : mag;
      end
    end
    mag = (acc < 0) ? -acc : acc;
    return {ovf, (acc < 0), 7'(mag)};
  endfunction

  task automatic set_blk(input logic [7:0] d0, d1, d2, d3, input logic s0, s1, s2, s3);
    blk_d[0] = d0; blk_d[1] = d1; blk_d[2] = d2; blk_d[3] = d3;
    blk_s[0] = s0; blk_s[1] = s1; blk_s[2] = s2; blk_s[3] = s3;
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic push_op(input logic [7:0] d, input logic s, input bit last);
    int n = 0;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_sub   = s;
    @(negedge clk);
    while (!a_if.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("op_timeout", 32'(n >= 64), 0);
    @(posedge clk); #1;
    drv_valid = 1'b0;
    if (last) begin
      @(negedge clk);
      check("latency_valid", a_if.out_valid, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_block();
    exp_a_q.push_back(model_result(1'b1, 4));
    exp_b_q.push_back(model_result(1'b0, 4));
    for (int i = 0; i < 4; i++) push_op(blk_d[i], blk_s[i], i == 3);
  endtask

  // Scoreboard: each cycle that ends in a transfer retires one expected result per copy.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rand_rdy) drv_rdy = 1'($urandom_range(0, 1));
    if (!rst && a_if.out_valid && a_if.out_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected", a_if.out_data, 32'hFFFF);
      else begin
        e = exp_a_q.pop_front();
        check("a_data", a_if.out_data, e[7:0]);
        check("a_ovf", a_if.out_ovf, e[8]);
      end
    end
    if (!rst && b_if.out_valid && b_if.out_ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", b_if.out_data, 32'hFFFF);
      else begin
        e = exp_b_q.pop_front();
        check("b_data", b_if.out_data, e[7:0]);
        check("b_ovf", b_if.out_ovf, e[8]);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold;
    logic [W-1:0] ce;
    int n;
    int last_acc;
    int acc_cnt;

    // Reset phase
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", a_if.in_ready, 0);
      check("rst_out_valid", a_if.out_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", a_if.in_ready, 1);
    check("post_rst_out_valid", a_if.out_valid, 0);
    check("post_rst_data", a_if.out_data, 0);
    check("post_rst_ovf", a_if.out_ovf, 0);
    check("post_rst_c_in_ready", c_if.in_ready, 1);
    @(posedge clk); #1;

    // Directed blocks: cancel to +0, sub of a negative, saturate/wrap
    set_blk(8'h04, 8'h87, 8'h02, 8'h01, 0, 0, 0, 0); run_block();
    set_blk(8'h0A, 8'h85, 8'h14, 8'hA8, 0, 1, 0, 0); run_block();
    set_blk(8'h64, 8'h64, 8'h9B, 8'h80, 0, 0, 0, 1); run_block();

    // Backpressure: held result, in_valid ignored while DONE
    drv_rdy = 1'b0;
    set_blk(8'h7F, 8'h05, 8'h83, 8'h10, 0, 0, 1, 0);
    run_block();
    hold = exp_a_q[$];
    drv_valid = 1'b1;
    drv_data  = 8'h11;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", a_if.out_valid, 1);
      check("bp_in_ready", a_if.in_ready, 0);
      check("bp_data", a_if.out_data, hold[7:0]);
      check("bp_ovf", a_if.out_ovf, hold[8]);
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_rdy   = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_in_ready", a_if.in_ready, 1);
    check("bp_idle_out_valid", a_if.out_valid, 0);
    @(posedge clk); #1;

    // Reset mid-block in ACC
    push_op(8'h05, 1'b0, 1'b0);
    push_op(8'h06, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", a_if.in_ready, 0);
    check("mid_rst_out_valid", a_if.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_blk(8'h01, 8'h01, 8'h01, 8'h01, 0, 0, 0, 0); run_block();

    // Reset while a result with overflow is held in DONE
    drv_rdy = 1'b0;
    set_blk(8'h64, 8'h64, 8'h00, 8'h00, 0, 0, 0, 0); run_block();
    void'(exp_a_q.pop_back());
    void'(exp_b_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    check("done_rst_out_valid", a_if.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drv_rdy = 1'b1;
    @(negedge clk);
    check("done_rst_idle_valid", a_if.out_valid, 0);
    check("done_rst_data", a_if.out_data, 0);
    check("done_rst_ovf", a_if.out_ovf, 0);
    check("done_rst_b_ovf", b_if.out_ovf, 0);
    @(posedge clk); #1;

    // Random blocks with random consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 4; i++) begin
        blk_d[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) << 7) : 8'($urandom_range(0, 255));
        blk_s[i] = 1'($urandom_range(0, 1));
      end
      run_block();
    end
    rand_rdy = 1'b0;
    drv_rdy  = 1'b1;
    n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    @(posedge clk); #1;

    // DEPTH=1: single operand result, then back-to-back with one bubble
    c_rdy   = 1'b0;
    c_data  = 8'h83;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(negedge clk);
    check("c_single_valid", c_if.out_valid, 1);
    check("c_single_data", c_if.out_data, 8'h83);
    check("c_single_ovf", c_if.out_ovf, 0);
    @(posedge clk); #1;
    c_rdy = 1'b1;
    @(posedge clk); #1;
    c_valid  = 1'b1;
    last_acc = -1;
    acc_cnt  = 0;
    ce       = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (c_if.out_valid) check("c_b2b_data", c_if.out_data, ce[7:0]);
      if (c_if.in_ready) begin
        if (last_acc >= 0) check("c_gap", k - last_acc, 2);
        last_acc = k;
        acc_cnt++;
        blk_d[0] = c_data;
        blk_s[0] = c_sub;
        ce = model_result(1'b1, 1);
      end
      @(posedge clk); #1;
      c_data = 8'($urandom_range(0, 255));
      c_sub  = 1'($urandom_range(0, 1));
    end
    c_valid = 1'b0;
    check("c_accept_count", acc_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
